// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the RISC-V core.
// Latency: a word fetched in cycle n is presented on if_id_* in cycle n+1; a redirect costs one bubble.
// Backpressure: stall holds pc and IF/ID; redirect overrides stall; HALTED ignores stall until a redirect arrives.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hazard-unit hold request for pc and IF/ID
//   redirect_valid/pc EX-stage branch/jump target (low two bits dropped)
//   imem_addr/rdata   combinational instruction memory read port (addr == pc)
//   if_id_*           registered instruction, its pc, pc+4, opcode and valid flag
//   halted            stage has fetched the HALT encoding and is parked
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] if_id_pc_nxt;
  logic [31:0] if_id_instr_nxt;
  logic        if_id_valid_nxt;
  logic [31:0] redirect_aligned;

  // Targets are word aligned; misaligned low bits from EX are simply discarded.
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_id_pc_nxt    = if_id_pc;
    if_id_instr_nxt = if_id_instr;
    if_id_valid_nxt = if_id_valid;

    case (state)
      RUN: begin
        if (redirect_valid) begin
          // Flush the wrong-path word; stall is irrelevant since that word is dead.
          pc_nxt          = redirect_aligned;
          if_id_instr_nxt = NOP_INSTR;
          if_id_valid_nxt = 1'b0;
        end else if (stall) begin
          // Hold everything.
        end else if (imem_rdata == HALT_INSTR) begin
          // Park on the HALT address; HALT itself never reaches decode.
          if_id_instr_nxt = NOP_INSTR;
          if_id_valid_nxt = 1'b0;
          state_nxt       = HALTED;
        end else begin
          if_id_pc_nxt    = pc;
          if_id_instr_nxt = imem_rdata;
          if_id_valid_nxt = 1'b1;
          pc_nxt          = pc + 32'd4;
        end
      end
      HALTED: begin
        if_id_instr_nxt = NOP_INSTR;
        if_id_valid_nxt = 1'b0;
        // A HALT may have been fetched behind a branch still resolving in EX.
        if (redirect_valid) begin
          pc_nxt    = redirect_aligned;
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0000_0000;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_pc    <= if_id_pc_nxt;
      if_id_instr <= if_id_instr_nxt;
      if_id_valid <= if_id_valid_nxt;
    end
  end

  assign imem_addr      = pc;
  assign if_id_pc_plus4 = if_id_pc + 32'd4;
  assign if_id_opcode   = if_id_instr[6:0];
  assign halted         = (state == HALTED);

endmodule
